// File: rtl/multi_data_sync.sv
// ============================================================================
// multi_data_sync
// ----------------------------------------------------------------------------
// Multi-channel enable-qualified synchronizer. Each of NUM_CH foreign-domain
// (bus_enable, data) pairs has its enable synchronized through a NUM_STAGES
// flop chain. A synchronized rising edge captures that channel's
// quasi-static data word into a hold register and marks it pending. A
// round-robin arbiter then presents pending words one at a time on a single
// valid/ready port in the CLK domain. Each channel has a sticky overrun flag.
//
// Configuration macro:
//   DATA_SYNC_OVR_CNT_EN  defined   : ovr_count is a saturating total count
//                                     of overrun events.
//                         undefined : counter omitted, ovr_count is 0.
//
// Parameters:
//   NUM_STAGES  synchronizer depth per enable (>= 2)
//   BUS_WIDTH   data width per channel
//   NUM_CH      channel count (1..16)
//   CH_W        width of out_ch (>= clog2(NUM_CH), 1 when NUM_CH = 1)
//   ERR_CNT_W   overrun counter width
//
// Ports:
//   CLK           in   destination clock, all state on the rising edge
//   RST           in   synchronous active-high reset
//   bus_enable    in   [NUM_CH]            async per-channel enable
//   UNSYNC_bus    in   [NUM_CH*BUS_WIDTH]  channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//   out_ready     in   consumer accepts SYNC_bus this cycle
//   ovr_clr       in   clears overrun flags and ovr_count
//   SYNC_bus      out  [BUS_WIDTH]  delivered data word
//   out_ch        out  [CH_W]       source channel of SYNC_bus
//   out_valid     out  SYNC_bus/out_ch valid, held until accepted
//   enable_pulse  out  one-cycle pulse when a new word is presented
//   overrun       out  [NUM_CH]     sticky per-channel overrun flags
//   ovr_count     out  [ERR_CNT_W]  saturating total overrun count
// ============================================================================
module multi_data_sync #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int ERR_CNT_W  = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH-1:0]           bus_enable,
    input  logic [NUM_CH*BUS_WIDTH-1:0] UNSYNC_bus,
    input  logic                        out_ready,
    input  logic                        ovr_clr,
    output logic [BUS_WIDTH-1:0]        SYNC_bus,
    output logic [CH_W-1:0]             out_ch,
    output logic                        out_valid,
    output logic                        enable_pulse,
    output logic [NUM_CH-1:0]           overrun,
    output logic [ERR_CNT_W-1:0]        ovr_count
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0][NUM_STAGES-1:0] stage_q;     // per-channel sync chains
    logic [NUM_CH-1:0]                 prev_q;      // last synchronized level
    logic [NUM_CH-1:0]                 pending_q;   // hold register not yet granted
    logic [NUM_CH-1:0][BUS_WIDTH-1:0]  hold_q;      // captured data per channel
    logic [CH_W-1:0]                   last_grant_q;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0]    sync;
    logic [NUM_CH-1:0]    rise;
    logic                 slot_free;
    logic                 grant_valid;
    logic [CH_W-1:0]      grant_ch;
    logic [BUS_WIDTH-1:0] grant_data;
    logic [NUM_CH-1:0]    grant_vec;    // one-hot of the arbiter winner
    logic                 do_grant;
    logic [NUM_CH-1:0]    granted;      // winner actually handed to the port
    logic [NUM_CH-1:0]    ovr_event;

    // NOTE: every variable written in an always_comb gets a default on entry,
    // so no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        sync = '0;
        rise = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sync[i] = stage_q[i][NUM_STAGES-1];
            rise[i] = sync[i] & ~prev_q[i];
        end
    end

    assign slot_free = ~out_valid | out_ready;

    // Round-robin search: offset k = 0 is the channel right after the last
    // grant. The inner loop finds the channel sitting at offset k, so the
    // first pending hit in k order is the winner. Data is muxed in the same
    // loop to avoid indexing the hold array with a CH_W-wide select.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        grant_data  = '0;
        grant_vec   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grant_valid && pending_q[i] &&
                    (((int'(last_grant_q) + 1 + k) % NUM_CH) == i)) begin
                    grant_valid  = 1'b1;
                    grant_ch     = CH_W'(i);
                    grant_data   = hold_q[i];
                    grant_vec[i] = 1'b1;
                end
            end
        end
    end

    assign do_grant = slot_free & grant_valid;
    assign granted  = grant_vec & {NUM_CH{slot_free}};

    // A rise on a channel whose previous word is still waiting (and is not
    // leaving this very cycle) loses that word.
    assign ovr_event = rise & pending_q & ~granted;

    // ------------------------------------------------------------------------
    // Synchronizers, edge detect, capture and pending bookkeeping
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            // NOTE: hold registers are reset too; a word must never appear
            // from before reset, and clearing them keeps the output
            // deterministic for any grant decision right after reset.
            hold_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                stage_q[i] <= {stage_q[i][NUM_STAGES-2:0], bus_enable[i]};
            end
            prev_q <= sync;
            for (int i = 0; i < NUM_CH; i++) begin
                if (rise[i]) begin
                    // Newest data wins. On a same-cycle grant the arbiter has
                    // already read the old content, so the new word stays
                    // pending.
                    hold_q[i]    <= UNSYNC_bus[i*BUS_WIDTH +: BUS_WIDTH];
                    pending_q[i] <= 1'b1;
                end else if (granted[i]) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output port and arbiter pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            SYNC_bus     <= '0;
            out_ch       <= '0;
            out_valid    <= 1'b0;
            enable_pulse <= 1'b0;
            last_grant_q <= CH_W'(NUM_CH - 1);   // channel 0 wins first
        end else if (do_grant) begin
            SYNC_bus     <= grant_data;
            out_ch       <= grant_ch;
            out_valid    <= 1'b1;
            enable_pulse <= 1'b1;
            last_grant_q <= grant_ch;
        end else begin
            // Data and channel keep their last values once accepted.
            enable_pulse <= 1'b0;
            if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky overrun flags: a same-cycle overrun beats the clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            overrun <= '0;
        end else if (ovr_clr) begin
            overrun <= ovr_event;
        end else begin
            overrun <= overrun | ovr_event;
        end
    end

    // ------------------------------------------------------------------------
    // Optional saturating overrun counter
    // ------------------------------------------------------------------------
`ifdef DATA_SYNC_OVR_CNT_EN
    // Wide enough to hold the current count plus every channel overrunning
    // in one cycle, so the saturation compare never wraps.
    localparam int SUM_W = ERR_CNT_W + $clog2(NUM_CH + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({ERR_CNT_W{1'b1}});

    logic [SUM_W-1:0] ovr_new;
    logic [SUM_W-1:0] ovr_base;
    logic [SUM_W-1:0] ovr_sum;

    always_comb begin
        ovr_new = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ovr_new = ovr_new + SUM_W'(ovr_event[i]);
        end
        // A clear restarts the count from the events of this cycle.
        ovr_base = ovr_clr ? '0 : SUM_W'(ovr_count);
        ovr_sum  = ovr_base + ovr_new;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovr_count <= '0;
        end else if (ovr_sum > CNT_MAX) begin
            ovr_count <= '1;
        end else begin
            ovr_count <= ovr_sum[ERR_CNT_W-1:0];
        end
    end
`else
    assign ovr_count = '0;
`endif

endmodule

// File: tb/tb_multi_data_sync.sv
// ============================================================================
// tb_multi_data_sync
// ----------------------------------------------------------------------------
// Directed bench for multi_data_sync with default parameters (NUM_STAGES=2,
// BUS_WIDTH=8, NUM_CH=4, CH_W=2, ERR_CNT_W=4). A per-cycle vector table
// covers reset, single-word latency and round-robin order; hand sequences
// cover backpressure, overrun, same-cycle grant/capture and reset
// mid-transfer. Inputs change 1 ns after the rising edge and outputs are
// sampled at the same point.
// ============================================================================
module tb_multi_data_sync;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  bus_enable;
    logic [31:0] UNSYNC_bus;
    logic        out_ready;
    logic        ovr_clr;
    logic [7:0]  SYNC_bus;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        enable_pulse;
    logic [3:0]  overrun;
    logic [3:0]  ovr_count;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DATA_SYNC_OVR_CNT_EN
    localparam logic [3:0] EXP_OVR_CNT = 4'd1;
`else
    localparam logic [3:0] EXP_OVR_CNT = 4'd0;
`endif

    multi_data_sync dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus_enable   (bus_enable),
        .UNSYNC_bus   (UNSYNC_bus),
        .out_ready    (out_ready),
        .ovr_clr      (ovr_clr),
        .SYNC_bus     (SYNC_bus),
        .out_ch       (out_ch),
        .out_valid    (out_valid),
        .enable_pulse (enable_pulse),
        .overrun      (overrun),
        .ovr_count    (ovr_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic [31:0] data;
        logic        rdy;
        logic        exp_v;
        logic        exp_p;
        logic [7:0]  exp_bus;
        logic [1:0]  exp_ch;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic rst, input logic [3:0] en, input logic [31:0] data,
                       input logic rdy, input logic v, input logic p,
                       input logic [7:0] bus, input logic [1:0] ch);
        vec_t r;
        r.rst = rst; r.en = en; r.data = data; r.rdy = rdy;
        r.exp_v = v; r.exp_p = p; r.exp_bus = bus; r.exp_ch = ch;
        vq.push_back(r);
    endtask

    task automatic check_out(input string tag, input logic v, input logic p,
                             input logic [7:0] bus, input logic [1:0] ch);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".pulse"}, 32'(enable_pulse), 32'(p));
        check({tag, ".bus"}, 32'(SYNC_bus), 32'(bus));
        check({tag, ".ch"}, 32'(out_ch), 32'(ch));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        RST = 1'b1; bus_enable = '0; UNSYNC_bus = '0; out_ready = 1'b1; ovr_clr = 1'b0;
        step();
        check_out("reset", 1'b0, 1'b0, 8'h00, 2'd0);
        check("reset.overrun", 32'(overrun), 32'h0);
        check("reset.ovr_count", 32'(ovr_count), 32'h0);

        // ---------------- table: single word + round robin ----------------
        //  rst en    data           rdy v  p  bus    ch
        add(1, 4'h0, 32'h0000_0000, 1, 0, 0, 8'h00, 2'd0);
        add(0, 4'h2, 32'h0000_F200, 1, 0, 0, 8'h00, 2'd0);   // E1
        add(0, 4'h2, 32'h0000_F200, 1, 0, 0, 8'h00, 2'd0);   // sync high
        add(0, 4'h2, 32'h0000_F200, 1, 0, 0, 8'h00, 2'd0);   // captured
        add(0, 4'h2, 32'h0000_F200, 1, 1, 1, 8'hF2, 2'd1);   // 4th edge
        add(0, 4'h2, 32'h0000_F200, 1, 0, 0, 8'hF2, 2'd1);
        add(0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'hF2, 2'd1);
        add(0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'hF2, 2'd1);
        add(0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'hF2, 2'd1);
        add(1, 4'h0, 32'h0000_0000, 1, 0, 0, 8'h00, 2'd0);   // reset: ch0 first
        add(0, 4'hD, 32'hCCBB_00AA, 1, 0, 0, 8'h00, 2'd0);
        add(0, 4'hD, 32'hCCBB_00AA, 1, 0, 0, 8'h00, 2'd0);
        add(0, 4'hD, 32'hCCBB_00AA, 1, 0, 0, 8'h00, 2'd0);
        add(0, 4'hD, 32'hCCBB_00AA, 1, 1, 1, 8'hAA, 2'd0);
        add(0, 4'hD, 32'hCCBB_00AA, 1, 1, 1, 8'hBB, 2'd2);
        add(0, 4'hD, 32'hCCBB_00AA, 1, 1, 1, 8'hCC, 2'd3);
        add(0, 4'hD, 32'hCCBB_00AA, 1, 0, 0, 8'hCC, 2'd3);
        add(0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'hCC, 2'd3);
        add(0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'hCC, 2'd3);
        add(0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'hCC, 2'd3);
        add(0, 4'h9, 32'hEE00_00DD, 1, 0, 0, 8'hCC, 2'd3);
        add(0, 4'h9, 32'hEE00_00DD, 1, 0, 0, 8'hCC, 2'd3);
        add(0, 4'h9, 32'hEE00_00DD, 1, 0, 0, 8'hCC, 2'd3);
        add(0, 4'h9, 32'hEE00_00DD, 1, 1, 1, 8'hDD, 2'd0);
        add(0, 4'h9, 32'hEE00_00DD, 1, 1, 1, 8'hEE, 2'd3);
        add(0, 4'h9, 32'hEE00_00DD, 1, 0, 0, 8'hEE, 2'd3);
        add(0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'hEE, 2'd3);
        add(0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'hEE, 2'd3);
        add(0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'hEE, 2'd3);

        foreach (vq[r]) begin
            RST = vq[r].rst; bus_enable = vq[r].en; UNSYNC_bus = vq[r].data; out_ready = vq[r].rdy;
            step();
            check_out($sformatf("vec%0d", r), vq[r].exp_v, vq[r].exp_p, vq[r].exp_bus, vq[r].exp_ch);
        end

        // ---------------- backpressure ----------------
        out_ready = 1'b0; UNSYNC_bus = 32'h0000_0011; bus_enable = 4'h1;
        repeat (4) step();
        check_out("bp.present", 1'b1, 1'b1, 8'h11, 2'd0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) bus_enable = 4'h0;
            step();
            if (enable_pulse) pulses++;
            check_out($sformatf("bp.hold%0d", c), 1'b1, 1'b0, 8'h11, 2'd0);
        end
        check("bp.pulse_count", 32'(pulses), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp.accepted", 32'(out_valid), 32'd0);
        repeat (2) step();

        // ---------------- overrun ----------------
        out_ready = 1'b0; UNSYNC_bus = 32'h0000_6600; bus_enable = 4'h2;
        repeat (4) step();
        check_out("ovr.block", 1'b1, 1'b1, 8'h66, 2'd1);
        bus_enable = 4'h4; UNSYNC_bus = 32'h0022_0000;
        repeat (4) step();
        bus_enable = 4'h0;
        repeat (3) step();
        check("ovr.before", 32'(overrun), 32'h0);
        UNSYNC_bus = 32'h0033_0000; bus_enable = 4'h4;
        repeat (2) step();
        check("ovr.not_yet", 32'(overrun), 32'h0);
        step();
        check("ovr.flag", 32'(overrun), 32'h4);
        check("ovr.count", 32'(ovr_count), 32'(EXP_OVR_CNT));
        check_out("ovr.still66", 1'b1, 1'b0, 8'h66, 2'd1);
        out_ready = 1'b1;
        step();
        check_out("ovr.deliver33", 1'b1, 1'b1, 8'h33, 2'd2);
        bus_enable = 4'h0;
        step();
        check("ovr.drained", 32'(out_valid), 32'd0);
        check("ovr.sticky", 32'(overrun), 32'h4);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("ovr.clr_flag", 32'(overrun), 32'h0);
        check("ovr.clr_count", 32'(ovr_count), 32'h0);
        repeat (2) step();

        // ---------------- same-cycle grant and capture on ch1 ----------------
        out_ready = 1'b0; UNSYNC_bus = 32'h0000_0077; bus_enable = 4'h1;
        repeat (4) step();
        check_out("gc.block", 1'b1, 1'b1, 8'h77, 2'd0);
        bus_enable = 4'h2; UNSYNC_bus = 32'h0000_4400;
        repeat (4) step();
        bus_enable = 4'h0;
        repeat (3) step();
        UNSYNC_bus = 32'h0000_5500; bus_enable = 4'h2;
        repeat (2) step();
        out_ready = 1'b1;     // grant of ch1 lands on the edge of its new rise
        step();
        check_out("gc.old44", 1'b1, 1'b1, 8'h44, 2'd1);
        check("gc.no_ovr", 32'(overrun), 32'h0);
        step();
        check_out("gc.new55", 1'b1, 1'b1, 8'h55, 2'd1);
        step();
        check("gc.drained", 32'(out_valid), 32'd0);
        check("gc.no_ovr2", 32'(overrun), 32'h0);
        bus_enable = 4'h0;
        repeat (3) step();

        // ---------------- reset mid-transfer ----------------
        out_ready = 1'b0; UNSYNC_bus = 32'hA3A2_00A0; bus_enable = 4'hD;
        repeat (4) step();
        check_out("rst.present", 1'b1, 1'b1, 8'hA2, 2'd2);
        bus_enable = 4'h8;    // ch3 stays high through reset
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_out("rst.cleared", 1'b0, 1'b0, 8'h00, 2'd0);
        check("rst.overrun", 32'(overrun), 32'h0);
        repeat (3) step();
        check("rst.no_stale", 32'(out_valid), 32'd0);
        step();
        check_out("rst.fresh_rise", 1'b1, 1'b1, 8'hA3, 2'd3);
        out_ready = 1'b1;
        step();
        check("rst.accept", 32'(out_valid), 32'd0);
        repeat (4) step();
        check("rst.no_ch0", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
